// File: rtl/cpu_bus_pkg.sv
// Shared types and default timing for the 68000-style CPU bus controller.
package cpu_bus_pkg;

   localparam int unsigned E_DIV_DEF   = 10;
   localparam int unsigned E_HIGH_DEF  = 4;
   localparam int unsigned TIMEOUT_DEF = 255;

   typedef enum logic [2:0] {
      StIdle,
      StMem,
      StEwait,
      StEcyc,
      StHold,
      StErr
   } state_e;

   function automatic logic [1:0] strobe_be(input logic uds_n, input logic lds_n);
      return {~uds_n, ~lds_n};
   endfunction

endpackage

// File: rtl/cpu_bus_ctrl_if.sv
// CPU strobes plus memory-side request/response, bundled for the bus controller.
interface cpu_bus_ctrl_if #(
   parameter int unsigned ADDR_W = 23,
   parameter int unsigned DATA_W = 16
);
   logic                as_n;
   logic                uds_n;
   logic                lds_n;
   logic                rw_n;
   logic [ADDR_W:1]     addr;
   logic                periph_sel;
   logic [15:0]         cpu_dout;
   logic [15:0]         cpu_din;
   logic                dtack_n;
   logic                berr_n;
   logic                vma_n;
   logic                mem_req;
   logic                mem_we;
   logic                mem_periph;
   logic [DATA_W/8-1:0] mem_be;
   logic [ADDR_W:1]     mem_addr;
   logic [DATA_W-1:0]   mem_wdata;
   logic [DATA_W-1:0]   mem_rdata;
   logic                mem_ack;

   modport master (
      output as_n, uds_n, lds_n, rw_n, addr, periph_sel, cpu_dout, mem_rdata, mem_ack,
      input  cpu_din, dtack_n, berr_n, vma_n, mem_req, mem_we, mem_periph, mem_be, mem_addr,
             mem_wdata
   );

   modport slave (
      input  as_n, uds_n, lds_n, rw_n, addr, periph_sel, cpu_dout, mem_rdata, mem_ack,
      output cpu_din, dtack_n, berr_n, vma_n, mem_req, mem_we, mem_periph, mem_be, mem_addr,
             mem_wdata
   );

endinterface

// File: rtl/cpu_e_clock.sv
// 6800-style E clock derived from the CPU phi1 enable: low for E_DIV-E_HIGH ticks, then high.
module cpu_e_clock
   import cpu_bus_pkg::*;
#(
   parameter int unsigned E_DIV  = E_DIV_DEF,
   parameter int unsigned E_HIGH = E_HIGH_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cpu_en_p,
   output logic [$clog2(E_DIV)-1:0] count,
   output logic                     e,
   output logic                     e_rising,
   output logic                     e_falling
);

   localparam int unsigned CntW = $clog2(E_DIV);
   localparam logic [CntW-1:0] HighStart = CntW'(E_DIV - E_HIGH);
   localparam logic [CntW-1:0] Last      = CntW'(E_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            rise_q, rise_d;
   logic            fall_q, fall_d;

   always_comb begin
      cnt_d  = cnt_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      if (cpu_en_p) begin
         if (cnt_q == Last) begin
            cnt_d  = '0;
            fall_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
         rise_d = (cnt_d == HighStart);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rise_q <= rise_d;
         fall_q <= fall_d;
      end
   end

   assign count     = cnt_q;
   assign e         = (cnt_q >= HighStart);
   assign e_rising  = rise_q;
   assign e_falling = fall_q;

endmodule

// File: rtl/cpu_bus_ctrl.sv
// Bridges 68000 async bus cycles to a single-request memory port, with 6800 E-cycle
// peripheral access and a bus-error timeout.
module cpu_bus_ctrl
   import cpu_bus_pkg::*;
#(
   parameter int unsigned ADDR_W  = 23,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned E_DIV   = E_DIV_DEF,
   parameter int unsigned E_HIGH  = E_HIGH_DEF,
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cpu_en_p,
   cpu_bus_ctrl_if.slave            bus,
   output logic                     e,
   output logic                     e_rising,
   output logic                     e_falling,
   output logic [$clog2(E_DIV)-1:0] e_count
);

   localparam int unsigned BeW = DATA_W / 8;
   localparam int unsigned ToW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_e          state_q, state_d;
   logic [ToW-1:0]  to_q, to_d, to_inc;
   logic            to_hit, start, abort;
   logic            dtack_n_q, dtack_n_d, berr_n_q, berr_n_d, vma_n_q, vma_n_d;
   logic            req_q, req_d, we_q, we_d, periph_q, periph_d;
   logic [BeW-1:0]  be_q, be_d, start_be;
   logic [ADDR_W:1] addr_q, addr_d;
   logic [15:0]     wdata_q, wdata_d, din_q, din_d, rdata_half;
   logic [1:0]      strb;

   cpu_e_clock #(
      .E_DIV (E_DIV),
      .E_HIGH(E_HIGH)
   ) u_e_clock (
      .clk      (clk),
      .reset    (reset),
      .cpu_en_p (cpu_en_p),
      .count    (e_count),
      .e        (e),
      .e_rising (e_rising),
      .e_falling(e_falling)
   );

   assign strb = strobe_be(bus.uds_n, bus.lds_n);

   // 32-bit memory is big-endian: addr[1]=0 selects the upper half-word.
   if (DATA_W == 32) begin : g_w32
      assign start_be      = bus.addr[1] ? {2'b00, strb} : {strb, 2'b00};
      assign rdata_half    = addr_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
      assign bus.mem_wdata = {wdata_q, wdata_q};
   end else begin : g_w16
      assign start_be      = strb;
      assign rdata_half    = bus.mem_rdata[15:0];
      assign bus.mem_wdata = wdata_q;
   end

   assign start  = cpu_en_p && !bus.as_n && (!bus.uds_n || !bus.lds_n);
   assign abort  = cpu_en_p && bus.as_n;
   assign to_inc = to_q + 1'b1;
   assign to_hit = (TIMEOUT != 0) && cpu_en_p && (to_inc == ToW'(TIMEOUT));

   always_comb begin
      state_d   = state_q;
      to_d      = to_q;
      dtack_n_d = dtack_n_q;
      berr_n_d  = berr_n_q;
      vma_n_d   = vma_n_q;
      req_d     = req_q;
      we_d      = we_q;
      periph_d  = periph_q;
      be_d      = be_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      din_d     = din_q;

      if ((state_q == StMem || state_q == StEwait || state_q == StEcyc) &&
          cpu_en_p && (TIMEOUT != 0)) begin
         to_d = to_inc;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = bus.periph_sel ? StEwait : StMem;
               req_d    = !bus.periph_sel;
               we_d     = !bus.rw_n;
               periph_d = bus.periph_sel;
               be_d     = start_be;
               addr_d   = bus.addr;
               wdata_d  = bus.cpu_dout;
               to_d     = '0;
            end
         end
         StMem: begin
            if (abort) begin
               state_d = StIdle;
               req_d   = 1'b0;
            end else if (bus.mem_ack) begin
               state_d   = StHold;
               req_d     = 1'b0;
               dtack_n_d = 1'b0;
               din_d     = rdata_half;
            end else if (to_hit) begin
               state_d  = StErr;
               req_d    = 1'b0;
               berr_n_d = 1'b0;
            end
         end
         StEwait: begin
            if (abort) begin
               state_d = StIdle;
            end else if (e_rising) begin
               state_d = StEcyc;
               vma_n_d = 1'b0;
               req_d   = 1'b1;
            end else if (to_hit) begin
               state_d  = StErr;
               berr_n_d = 1'b0;
            end
         end
         StEcyc: begin
            if (abort) begin
               state_d = StIdle;
               req_d   = 1'b0;
               vma_n_d = 1'b1;
            end else begin
               if (bus.mem_ack) req_d = 1'b0;
               // Data is taken at E fall whether or not the peripheral acknowledged.
               if (e_falling) begin
                  state_d   = StHold;
                  req_d     = 1'b0;
                  vma_n_d   = 1'b1;
                  dtack_n_d = 1'b0;
                  din_d     = rdata_half;
               end else if (to_hit && !bus.mem_ack) begin
                  state_d  = StErr;
                  req_d    = 1'b0;
                  vma_n_d  = 1'b1;
                  berr_n_d = 1'b0;
               end
            end
         end
         StHold, StErr: begin
            if (abort) begin
               state_d   = StIdle;
               dtack_n_d = 1'b1;
               berr_n_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         to_q      <= '0;
         dtack_n_q <= 1'b1;
         berr_n_q  <= 1'b1;
         vma_n_q   <= 1'b1;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         periph_q  <= 1'b0;
         be_q      <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         din_q     <= '0;
      end else begin
         state_q   <= state_d;
         to_q      <= to_d;
         dtack_n_q <= dtack_n_d;
         berr_n_q  <= berr_n_d;
         vma_n_q   <= vma_n_d;
         req_q     <= req_d;
         we_q      <= we_d;
         periph_q  <= periph_d;
         be_q      <= be_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         din_q     <= din_d;
      end
   end

   assign bus.dtack_n    = dtack_n_q;
   assign bus.berr_n     = berr_n_q;
   assign bus.vma_n      = vma_n_q;
   assign bus.mem_req    = req_q;
   assign bus.mem_we     = we_q;
   assign bus.mem_periph = periph_q;
   assign bus.mem_be     = be_q;
   assign bus.mem_addr   = addr_q;
   assign bus.cpu_din    = din_q;

endmodule

// File: tb/tb_cpu_bus_ctrl.sv
// Directed bench for cpu_bus_ctrl: a 16-bit instance (TIMEOUT=8) and a 32-bit instance.
module tb_cpu_bus_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       cpu_en_p;
   logic       e16, er16, ef16, e32, er32, ef32;
   logic [3:0] cnt16, cnt32;
   int         checks = 0;
   int         failures = 0;

   typedef struct {
      string       tag;
      logic [15:0] din;
      logic        berr_n;
   } exp_t;
   exp_t sb[$];

   cpu_bus_ctrl_if #(.ADDR_W(23), .DATA_W(16)) b16 ();
   cpu_bus_ctrl_if #(.ADDR_W(23), .DATA_W(32)) b32 ();

   cpu_bus_ctrl #(
      .ADDR_W(23), .DATA_W(16), .E_DIV(10), .E_HIGH(4), .TIMEOUT(8)
   ) dut16 (
      .clk(clk), .reset(reset), .cpu_en_p(cpu_en_p), .bus(b16.slave),
      .e(e16), .e_rising(er16), .e_falling(ef16), .e_count(cnt16)
   );

   cpu_bus_ctrl #(
      .ADDR_W(23), .DATA_W(32), .E_DIV(10), .E_HIGH(4), .TIMEOUT(255)
   ) dut32 (
      .clk(clk), .reset(reset), .cpu_en_p(cpu_en_p), .bus(b32.slave),
      .e(e32), .e_rising(er32), .e_falling(ef32), .e_count(cnt32)
   );

   always #5 clk = ~clk;

   // phi1 enable on every other clock
   initial begin
      cpu_en_p = 1'b0;
      forever @(negedge clk) cpu_en_p = ~cpu_en_p;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   // Scoreboard: each dtack_n/berr_n fall on the 16-bit port pops one expected completion.
   logic prev_dt = 1'b1;
   logic prev_be = 1'b1;
   always @(negedge clk) begin
      exp_t x;
      if (!reset && ((prev_dt && !b16.dtack_n) || (prev_be && !b16.berr_n))) begin
         checks++;
         assert (sb.size() > 0) else begin
            failures++;
            $error("FAIL sb_unexpected observed=completion expected=none");
         end
         if (sb.size() > 0) begin
            x = sb.pop_front();
            chk({x.tag, "_din"}, 32'(b16.cpu_din), 32'(x.din));
            chk({x.tag, "_berr"}, 32'(b16.berr_n), 32'(x.berr_n));
            chk({x.tag, "_dtack"}, 32'(b16.dtack_n), 32'(!x.berr_n));
         end
      end
      prev_dt = b16.dtack_n;
      prev_be = b16.berr_n;
   end

   task automatic start16(input logic [23:1] a, input logic rw, input logic u, input logic l,
                          input logic [15:0] d, input logic p);
      b16.addr = a; b16.rw_n = rw; b16.uds_n = u; b16.lds_n = l;
      b16.cpu_dout = d; b16.periph_sel = p; b16.as_n = 1'b0;
   endtask

   task automatic wait_req16(input string tag);
      for (int i = 0; i < 20 && b16.mem_req !== 1'b1; i++) @(negedge clk);
      chk(tag, 32'(b16.mem_req), 32'd1);
   endtask

   task automatic ack16(input logic [15:0] d);
      b16.mem_rdata = d; b16.mem_ack = 1'b1;
      @(negedge clk);
      b16.mem_ack = 1'b0;
   endtask

   task automatic wait_dtack16(input string tag);
      for (int i = 0; i < 20 && b16.dtack_n !== 1'b0; i++) @(negedge clk);
      chk(tag, 32'(b16.dtack_n), 32'd0);
   endtask

   task automatic release16(input string tag);
      b16.as_n = 1'b1; b16.uds_n = 1'b1; b16.lds_n = 1'b1; b16.periph_sel = 1'b0;
      for (int i = 0; i < 10 && {b16.dtack_n, b16.berr_n} !== 2'b11; i++) @(negedge clk);
      chk(tag, 32'({b16.dtack_n, b16.berr_n}), 32'b11);
   endtask

   task automatic release32(input string tag);
      b32.as_n = 1'b1; b32.uds_n = 1'b1; b32.lds_n = 1'b1;
      for (int i = 0; i < 10 && b32.dtack_n !== 1'b1; i++) @(negedge clk);
      chk(tag, 32'(b32.dtack_n), 32'd1);
   endtask

   task automatic chk_reset16(input string tag);
      chk(tag, 32'({b16.dtack_n, b16.berr_n, b16.vma_n, b16.mem_req, b16.mem_we,
                    b16.mem_periph, b16.mem_be, e16, er16, ef16}), 32'b111_000_00_000);
      chk({tag, "_din_cnt"}, 32'({b16.cpu_din, cnt16}), 32'd0);
   endtask

   initial begin
      logic rise_seen, fall_seen;
      int   n;

      reset = 1'b1;
      b16.as_n = 1'b1; b16.uds_n = 1'b1; b16.lds_n = 1'b1; b16.rw_n = 1'b1;
      b16.addr = '0; b16.periph_sel = 1'b0; b16.cpu_dout = '0;
      b16.mem_rdata = '0; b16.mem_ack = 1'b0;
      b32.as_n = 1'b1; b32.uds_n = 1'b1; b32.lds_n = 1'b1; b32.rw_n = 1'b1;
      b32.addr = '0; b32.periph_sel = 1'b0; b32.cpu_dout = '0;
      b32.mem_rdata = '0; b32.mem_ack = 1'b0;
      repeat (4) @(negedge clk);
      chk_reset16("reset16");
      chk("reset32", 32'({b32.dtack_n, b32.berr_n, b32.vma_n, b32.mem_req, b32.mem_we,
                         b32.mem_periph, b32.mem_be, e32, er32, ef32, cnt32}),
          32'b111_000_0000_000_0000);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // 16-bit read, ack three clocks after the request
      start16(23'h12345, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      wait_req16("rd_req");
      chk("rd_addr_be_we", 32'({b16.mem_addr, b16.mem_be, b16.mem_we}), {23'h12345, 2'b11, 1'b0});
      sb.push_back('{tag: "rd16", din: 16'h1234, berr_n: 1'b1});
      repeat (2) @(negedge clk);
      ack16(16'h1234);
      b16.mem_rdata = 16'hDEAD;
      wait_dtack16("rd_dtack");
      chk("rd_req_drop", 32'(b16.mem_req), 32'd0);
      repeat (6) @(negedge clk);
      chk("rd_hold", 32'({b16.dtack_n, b16.cpu_din}), {15'd0, 1'b0, 16'h1234});
      release16("rd_release");

      // 16-bit write, low byte only; bus inputs change after start
      start16(23'h00010, 1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b0);
      wait_req16("wr_req");
      chk("wr_be_we", 32'({b16.mem_be, b16.mem_we}), 32'b011);
      b16.addr = '0; b16.cpu_dout = 16'h0000;
      @(negedge clk);
      chk("wr_stable", 32'({b16.mem_addr, b16.mem_wdata}), {23'h00010, 16'h5A5A});
      sb.push_back('{tag: "wr16", din: 16'h0F0F, berr_n: 1'b1});
      ack16(16'h0F0F);
      wait_dtack16("wr_dtack");
      release16("wr_release");

      // peripheral read started at E count 2
      for (int i = 0; i < 60 && cnt16 !== 4'd2; i++) @(negedge clk);
      chk("per_cnt_start", 32'(cnt16), 32'd2);
      start16(23'h7F000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
      sb.push_back('{tag: "per", din: 16'hBEEF, berr_n: 1'b1});
      repeat (3) @(negedge clk);
      chk("per_ewait", 32'({b16.mem_req, b16.vma_n}), 32'b01);
      rise_seen = 1'b0;
      for (int i = 0; i < 60 && b16.vma_n !== 1'b0; i++) begin
         rise_seen = er16;
         @(negedge clk);
      end
      chk("per_vma", 32'({b16.vma_n, rise_seen, e16, cnt16}), {25'd0, 1'b0, 1'b1, 1'b1, 4'd6});
      chk("per_req", 32'({b16.mem_req, b16.mem_periph}), 32'b11);
      repeat (2) @(negedge clk);
      ack16(16'hBEEF);
      chk("per_ack", 32'({b16.mem_req, b16.vma_n, b16.dtack_n}), 32'b001);
      fall_seen = 1'b0;
      for (int i = 0; i < 60 && b16.dtack_n !== 1'b0; i++) begin
         fall_seen = ef16;
         @(negedge clk);
      end
      chk("per_dtack", 32'({b16.dtack_n, fall_seen, e16, b16.vma_n, cnt16}),
          {24'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0});
      release16("per_release");

      // no acknowledge: bus error after 8 enable ticks
      start16(23'h00100, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      wait_req16("tmo_req");
      sb.push_back('{tag: "tmo", din: 16'hBEEF, berr_n: 1'b0});
      n = 0;
      for (int i = 0; i < 40 && b16.berr_n !== 1'b0; i++) begin
         @(posedge clk);
         if (cpu_en_p) n++;
         @(negedge clk);
      end
      chk("tmo_ticks", 32'(n), 32'd8);
      chk("tmo_outs", 32'({b16.berr_n, b16.mem_req, b16.dtack_n}), 32'b001);
      repeat (4) @(negedge clk);
      chk("tmo_hold", 32'(b16.berr_n), 32'd0);
      release16("tmo_release");

      // acknowledge on the same tick the timeout would fire
      start16(23'h00200, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      wait_req16("aw_req");
      sb.push_back('{tag: "ackwin", din: 16'h7777, berr_n: 1'b1});
      n = 0;
      for (int i = 0; i < 40 && n < 7; i++) begin
         @(posedge clk);
         if (cpu_en_p) n++;
      end
      @(negedge clk);
      @(negedge clk);
      ack16(16'h7777);
      wait_dtack16("aw_dtack");
      chk("aw_berr", 32'(b16.berr_n), 32'd1);
      release16("aw_release");

      // aborted cycle: a late acknowledge must be ignored
      start16(23'h00300, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      wait_req16("ab_req");
      b16.as_n = 1'b1; b16.uds_n = 1'b1; b16.lds_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("ab_drop", 32'({b16.mem_req, b16.dtack_n, b16.berr_n}), 32'b011);
      ack16(16'h4444);
      repeat (3) @(negedge clk);
      chk("ab_late_ack", 32'({b16.dtack_n, b16.cpu_din}), {15'd0, 1'b1, 16'h7777});

      // reset in the middle of a memory cycle
      start16(23'h00400, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
      wait_req16("rst_req");
      reset = 1'b1;
      b16.as_n = 1'b1; b16.uds_n = 1'b1; b16.lds_n = 1'b1;
      @(negedge clk);
      chk_reset16("rst_mid");
      reset = 1'b0;
      @(negedge clk);
      chk("rst_after", 32'({b16.mem_req, b16.dtack_n}), 32'b01);

      // 32-bit write to the lower half, upper byte strobe only
      b32.addr = 23'h000003; b32.rw_n = 1'b0; b32.uds_n = 1'b0; b32.lds_n = 1'b1;
      b32.cpu_dout = 16'hABCD; b32.as_n = 1'b0;
      for (int i = 0; i < 20 && b32.mem_req !== 1'b1; i++) @(negedge clk);
      chk("w32_req_we", 32'({b32.mem_req, b32.mem_we}), 32'b11);
      chk("w32_be", 32'(b32.mem_be), 32'b0010);
      chk("w32_wdata", b32.mem_wdata, 32'hABCDABCD);
      chk("w32_addr", 32'(b32.mem_addr), 32'h000003);
      b32.mem_ack = 1'b1;
      @(negedge clk);
      b32.mem_ack = 1'b0;
      for (int i = 0; i < 20 && b32.dtack_n !== 1'b0; i++) @(negedge clk);
      chk("w32_dtack", 32'(b32.dtack_n), 32'd0);
      release32("w32_release");

      // 32-bit read from the upper half
      b32.addr = 23'h000004; b32.rw_n = 1'b1; b32.uds_n = 1'b0; b32.lds_n = 1'b0;
      b32.as_n = 1'b0;
      for (int i = 0; i < 20 && b32.mem_req !== 1'b1; i++) @(negedge clk);
      chk("r32_be", 32'(b32.mem_be), 32'b1100);
      b32.mem_rdata = 32'h1111_2222; b32.mem_ack = 1'b1;
      @(negedge clk);
      b32.mem_ack = 1'b0;
      for (int i = 0; i < 20 && b32.dtack_n !== 1'b0; i++) @(negedge clk);
      chk("r32_din", 32'({b32.dtack_n, b32.cpu_din}), {15'd0, 1'b0, 16'h1111});
      release32("r32_release");

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cpu_bus_ctrl.md
CPU_BUS_CTRL -- requirements
Module: cpu_bus_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, CPU word-address width (addr[ADDR_W:1]).
REQ-002 SHALL have parameter DATA_W, default 16, memory data width; legal values 16 and 32 only.
REQ-003 SHALL have parameter E_DIV, default 10, cpu_en_p ticks per E period; E_HIGH, default 4, ticks of E high.
REQ-004 SHALL have parameter TIMEOUT, default 255, cpu_en_p ticks before bus error; 0 disables.
REQ-005 clk  in  1  system clock; one clock, all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 cpu_en_p  in  1  CPU phi1 clock enable; all bus sampling and counting advances only on it.
REQ-008 as_n, uds_n, lds_n, rw_n  in  1 each  CPU bus strobes, active low; rw_n=1 read.
REQ-009 addr  in  ADDR_W  CPU word address; periph_sel  in  1  decode says 6800-style peripheral cycle.
REQ-010 cpu_dout  in  16  CPU write data; cpu_din  out  16  read data to CPU.
REQ-011 dtack_n, berr_n, vma_n  out  1 each  CPU handshake outputs, active low.
REQ-012 e, e_rising, e_falling  out  1 each  E clock level and one-clk pulses at its edges.
REQ-013 mem_req, mem_we, mem_periph  out  1 each; mem_be  out  DATA_W/8; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W.
REQ-014 mem_rdata  in  DATA_W; mem_ack  in  1  single-clk completion pulse from memory side.

Function
REQ-015 E counter SHALL count 0..E_DIV-1 on cpu_en_p, wrap to 0; e=1 when count >= E_DIV-E_HIGH.
REQ-016 e_rising SHALL pulse one clk when count enters E_DIV-E_HIGH; e_falling when count wraps to 0.
REQ-017 FSM states IDLE, MEM, EWAIT, ECYC, HOLD, ERR.
REQ-018 IDLE: on cpu_en_p with as_n=0 and (uds_n=0 or lds_n=0): periph_sel=0 -> MEM, else -> EWAIT; timeout counter cleared.
REQ-019 MEM: mem_req high until mem_ack; on mem_ack latch read data, dtack_n=0, -> HOLD.
REQ-020 EWAIT: wait for e_rising; then vma_n=0, mem_req=1 with mem_periph=1, -> ECYC.
REQ-021 ECYC: mem_req drops on mem_ack; at next e_falling latch mem_rdata (ack or not), dtack_n=0, vma_n=1, -> HOLD.
REQ-022 HOLD/ERR: outputs held until as_n samples 1 on cpu_en_p, then dtack_n=1, berr_n=1, -> IDLE.
REQ-023 Timeout counter increments each cpu_en_p in MEM/EWAIT/ECYC; reaching TIMEOUT -> ERR with berr_n=0, mem_req=0, vma_n=1, dtack_n stays 1.
REQ-024 mem_ack and timeout on same clk: ack wins, -> HOLD.
REQ-025 as_n rising while in MEM/EWAIT/ECYC (aborted cycle): drop mem_req and vma_n, -> IDLE; a later mem_ack is ignored.
REQ-026 mem_we = ~rw_n latched at cycle start; mem_addr, strobes, data latched at cycle start and stable throughout.
REQ-027 DATA_W=16: mem_be={~uds_n,~lds_n}; mem_wdata=cpu_dout; cpu_din=mem_rdata.
REQ-028 DATA_W=32: big-endian; addr[1]=0 -> mem_be[3:2]={~uds_n,~lds_n}, mem_be[1:0]=0, cpu_din=mem_rdata[31:16]; addr[1]=1 -> lower half; mem_wdata=cpu_dout replicated to both halves.
REQ-029 cpu_din SHALL be registered and stable from dtack_n falling until HOLD exits.

Reset
REQ-030 On reset: FSM=IDLE, E counter=0, e=0, e_rising=e_falling=0, dtack_n=berr_n=vma_n=1, mem_req=mem_we=mem_periph=0, mem_be=0, cpu_din=0, timeout counter=0.
REQ-031 Reset mid-cycle SHALL abort immediately; no mem_req in the clk after reset deasserts unless a new cycle starts.

Structure
REQ-032 Shared package cpu_bus_pkg SHALL hold the FSM state enum and E_DIV/E_HIGH/TIMEOUT defaults.
REQ-033 E clock generator SHALL be sub-module cpu_e_clock (count, e, e_rising, e_falling), reused elsewhere.

Verification
REQ-034 16-bit read, mem_ack 3 clks after mem_req, mem_rdata=0x1234 -> cpu_din=0x1234, dtack_n low until as_n high.
REQ-035 DATA_W=32 write, addr[1]=1, uds_n=0 lds_n=1, cpu_dout=0xABCD -> mem_be=4'b0010, mem_wdata=0xABCDABCD.
REQ-036 periph_sel=1 read at E count 2, E_DIV=10 -> vma_n low at e_rising (count 6), dtack_n low after e_falling, data latched then.
REQ-037 TIMEOUT=8, no mem_ack -> berr_n low after 8 cpu_en_p ticks, mem_req=0, released when as_n high.
REQ-038 mem_ack coincident with timeout tick -> dtack_n=0, berr_n stays 1; reset asserted in MEM -> all outputs at reset values next clk.
